// File: rtl/interrupt_ack_controller.sv
// Interrupt acknowledge controller: request/ISR priority arbitration, two-pulse
// INTA sequencing, vector generation, OCW2 EOI/rotation and automatic EOI.
module interrupt_ack_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] highest_request,
  input  logic [7:0] highest_isr,
  input  logic       inta,
  input  logic       ocw2_write,
  input  logic [7:0] ocw2_data,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic       in_service_flag,
  output logic [7:0] in_service_vector,
  output logic [7:0] eoi,
  output logic [2:0] rotate,
  output logic [7:0] vector_out,
  output logic       vector_enable
);

  localparam int unsigned IrW  = 8;
  localparam int unsigned IdxW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ACK1    = 2'd2
  } state_t;

  state_t             state, next_state;
  logic [IrW-1:0]     latch;
  logic               rotate_in_aeoi;

  logic [IdxW-1:0]    req_level, isr_level, isr_idx, ack_idx, ocw_level;
  logic               request_wins, aeoi_event;
  logic [2:0]         ocw_cmd;
  logic [IrW-1:0]     ocw_eoi_mask;
  logic               ocw_rot_en, ocw_set_raeoi, ocw_clr_raeoi;
  logic [IdxW-1:0]    ocw_rot_val;
  logic               unused_ocw_bits;

  function automatic logic [IdxW-1:0] onehot_idx(input logic [IrW-1:0] v);
    logic [IdxW-1:0] idx;
    idx = '0;
    for (int i = 0; i < IrW; i++) begin
      if (v[i]) idx = IdxW'(i);
    end
    return idx;
  endfunction

  // Level 0 is the IR just above the current lowest-priority IR.
  function automatic logic [IdxW-1:0] level(input logic [IdxW-1:0] n,
                                            input logic [IdxW-1:0] rot);
    return IdxW'(n - rot - IdxW'(1));
  endfunction

  assign unused_ocw_bits = ^ocw2_data[4:3];

  always_comb begin
    isr_idx      = onehot_idx(highest_isr);
    req_level    = level(onehot_idx(highest_request), rotate);
    isr_level    = level(isr_idx, rotate);
    request_wins = (highest_request != '0) &&
                   ((highest_isr == '0) || (req_level < isr_level));
    ack_idx      = (latch == '0) ? IdxW'(7) : onehot_idx(latch);
    aeoi_event   = (state == ACK1) && inta && auto_eoi && (latch != '0);
  end

  // OCW2 decode; non-specific commands naturally yield nothing when no ISR bit is set.
  always_comb begin
    ocw_cmd       = ocw2_data[7:5];
    ocw_level     = ocw2_data[2:0];
    ocw_eoi_mask  = '0;
    ocw_rot_en    = 1'b0;
    ocw_rot_val   = rotate;
    ocw_set_raeoi = 1'b0;
    ocw_clr_raeoi = 1'b0;
    if (ocw2_write) begin
      case (ocw_cmd)
        3'b001: ocw_eoi_mask = highest_isr;
        3'b011: ocw_eoi_mask = IrW'(1) << ocw_level;
        3'b101: begin
          ocw_eoi_mask = highest_isr;
          ocw_rot_en   = (highest_isr != '0);
          ocw_rot_val  = isr_idx;
        end
        3'b111: begin
          ocw_eoi_mask = IrW'(1) << ocw_level;
          ocw_rot_en   = 1'b1;
          ocw_rot_val  = ocw_level;
        end
        3'b110: begin
          ocw_rot_en  = 1'b1;
          ocw_rot_val = ocw_level;
        end
        3'b100:  ocw_set_raeoi = 1'b1;
        3'b000:  ocw_clr_raeoi = 1'b1;
        default: ;
      endcase
    end
  end

  // INTA has priority over request arbitration.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, PENDING: begin
        if (inta)              next_state = ACK1;
        else if (request_wins) next_state = PENDING;
        else                   next_state = IDLE;
      end
      ACK1:    if (inta) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      latch             <= '0;
      rotate_in_aeoi    <= 1'b0;
      rotate            <= 3'b111;
      int_out           <= 1'b0;
      in_service_flag   <= 1'b0;
      in_service_vector <= '0;
      eoi               <= '0;
      vector_out        <= '0;
      vector_enable     <= 1'b0;
    end else begin
      state           <= next_state;
      int_out         <= (next_state == PENDING);
      in_service_flag <= 1'b0;
      vector_enable   <= 1'b0;
      eoi             <= ocw_eoi_mask | (aeoi_event ? latch : '0);

      if (ocw_set_raeoi)      rotate_in_aeoi <= 1'b1;
      else if (ocw_clr_raeoi) rotate_in_aeoi <= 1'b0;

      if (ocw_rot_en)                         rotate <= ocw_rot_val;
      else if (aeoi_event && rotate_in_aeoi)  rotate <= ack_idx;

      if (inta && (state != ACK1)) begin
        latch <= highest_request;
        if (highest_request != '0) begin
          in_service_flag   <= 1'b1;
          in_service_vector <= highest_request;
        end
      end

      if (inta && (state == ACK1)) begin
        vector_out    <= {vector_base, ack_idx};
        vector_enable <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Directed bench for interrupt_ack_controller: arbitration, INTA sequence,
// spurious acknowledge, AEOI rotation, OCW2 commands and async reset abort.
module tb_interrupt_ack_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] highest_request, highest_isr, ocw2_data;
  logic       inta, ocw2_write, auto_eoi;
  logic [4:0] vector_base;
  logic       int_out, in_service_flag, vector_enable;
  logic [7:0] in_service_vector, eoi, vector_out;
  logic [2:0] rotate;

  int n_cmp = 0;
  int n_err = 0;

  interrupt_ack_controller dut (
    .clock             (clock),
    .reset             (reset),
    .highest_request   (highest_request),
    .highest_isr       (highest_isr),
    .inta              (inta),
    .ocw2_write        (ocw2_write),
    .ocw2_data         (ocw2_data),
    .auto_eoi          (auto_eoi),
    .vector_base       (vector_base),
    .int_out           (int_out),
    .in_service_flag   (in_service_flag),
    .in_service_vector (in_service_vector),
    .eoi               (eoi),
    .rotate            (rotate),
    .vector_out        (vector_out),
    .vector_enable     (vector_enable)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_inta();
    inta = 1'b1;
    tick();
    inta = 1'b0;
  endtask

  task automatic write_ocw2(input logic [7:0] d);
    ocw2_write = 1'b1;
    ocw2_data  = d;
    tick();
    ocw2_write = 1'b0;
    ocw2_data  = 8'h00;
  endtask

  initial begin
    reset = 1'b1; highest_request = 8'h00; highest_isr = 8'h00; ocw2_data = 8'h00;
    inta = 1'b0; ocw2_write = 1'b0; auto_eoi = 1'b0; vector_base = 5'h08;
    tick(); tick();
    chk("rst_int_out", 32'(int_out), 32'd0);
    chk("rst_rotate", 32'(rotate), 32'd7);
    chk("rst_eoi", 32'(eoi), 32'd0);
    chk("rst_vec_en", 32'(vector_enable), 32'd0);
    chk("rst_isf", 32'(in_service_flag), 32'd0);
    chk("rst_vec_out", 32'(vector_out), 32'd0);
    reset = 1'b0;
    tick();

    // V1: basic acknowledge of IR2, request changes after the first INTA are ignored
    highest_request = 8'h04;
    tick();
    chk("v1_int_out", 32'(int_out), 32'd1);
    pulse_inta();
    chk("v1_isf", 32'(in_service_flag), 32'd1);
    chk("v1_isv", 32'(in_service_vector), 32'h04);
    chk("v1_int_out_ack", 32'(int_out), 32'd0);
    highest_request = 8'h80;
    tick();
    chk("v1_isf_drop", 32'(in_service_flag), 32'd0);
    pulse_inta();
    chk("v1_vec_out", 32'(vector_out), 32'h42);
    chk("v1_vec_en", 32'(vector_enable), 32'd1);
    chk("v1_eoi", 32'(eoi), 32'd0);
    highest_request = 8'h00;
    tick();
    chk("v1_vec_en_drop", 32'(vector_enable), 32'd0);
    tick();

    // V2: request loses against in-service IR1 until rotation makes IR2 highest
    highest_request = 8'h08; highest_isr = 8'h02;
    tick(); tick();
    chk("v2_blocked", 32'(int_out), 32'd0);
    write_ocw2(8'hC1);
    chk("v2_rotate", 32'(rotate), 32'd1);
    chk("v2_set_rot_eoi", 32'(eoi), 32'd0);
    tick();
    chk("v2_wins", 32'(int_out), 32'd1);
    highest_request = 8'h00; highest_isr = 8'h00;
    tick();
    chk("v2_drop", 32'(int_out), 32'd0);
    write_ocw2(8'hC7);

    // V3: AEOI with rotate_in_aeoi on IR5
    auto_eoi = 1'b1;
    write_ocw2(8'h80);
    highest_request = 8'h20;
    pulse_inta();
    chk("v3_isv", 32'(in_service_vector), 32'h20);
    highest_request = 8'h00;
    tick();
    pulse_inta();
    chk("v3_vec_en", 32'(vector_enable), 32'd1);
    chk("v3_vec_out", 32'(vector_out), 32'h45);
    chk("v3_eoi", 32'(eoi), 32'h20);
    chk("v3_rotate", 32'(rotate), 32'd5);
    tick();
    chk("v3_eoi_drop", 32'(eoi), 32'd0);
    chk("v3_rotate_hold", 32'(rotate), 32'd5);
    auto_eoi = 1'b0;
    write_ocw2(8'h00);
    write_ocw2(8'hC7);

    // V4: request withdrawn in the INTA cycle gives a spurious acknowledge
    highest_request = 8'h10;
    tick();
    chk("v4_pending", 32'(int_out), 32'd1);
    highest_request = 8'h00;
    pulse_inta();
    chk("v4_no_isf", 32'(in_service_flag), 32'd0);
    tick();
    pulse_inta();
    chk("v4_vec_out", 32'(vector_out), 32'h47);
    chk("v4_vec_en", 32'(vector_enable), 32'd1);
    tick();

    // V5: specific EOI with rotate, then non-specific EOI/rotate with empty ISR
    highest_isr = 8'h08;
    write_ocw2(8'hE3);
    chk("v5_eoi", 32'(eoi), 32'h08);
    chk("v5_rotate", 32'(rotate), 32'd3);
    tick();
    chk("v5_eoi_drop", 32'(eoi), 32'd0);
    highest_isr = 8'h00;
    write_ocw2(8'h20);
    chk("v5_ns_eoi_empty", 32'(eoi), 32'd0);
    write_ocw2(8'hA0);
    chk("v5_ns_rot_empty", 32'(rotate), 32'd3);
    highest_isr = 8'h40;
    write_ocw2(8'h20);
    chk("v5_ns_eoi", 32'(eoi), 32'h40);
    highest_isr = 8'h00;

    // V6: asynchronous reset between the two INTA pulses
    write_ocw2(8'hC4);
    highest_request = 8'h02;
    pulse_inta();
    chk("v6_isf", 32'(in_service_flag), 32'd1);
    reset = 1'b1;
    #1;
    chk("v6_async_isf", 32'(in_service_flag), 32'd0);
    chk("v6_async_isv", 32'(in_service_vector), 32'd0);
    chk("v6_async_rotate", 32'(rotate), 32'd7);
    chk("v6_async_int", 32'(int_out), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("v6_no_vec_en", 32'(vector_enable), 32'd0);
    pulse_inta();
    chk("v6_new_isf", 32'(in_service_flag), 32'd1);
    chk("v6_new_isv", 32'(in_service_vector), 32'h02);
    highest_request = 8'h00;
    tick();
    pulse_inta();
    chk("v6_vec_out", 32'(vector_out), 32'h41);
    chk("v6_vec_en", 32'(vector_enable), 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_ack_controller.md
INTERRUPT_ACK_CONTROLLER -- requirements
Module: interrupt_ack_controller

Interface
REQ-001 clock  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state immediately, independent of clock.
REQ-003 highest_request  in  8  one-hot highest-priority unmasked IR from the priority resolver, or 0 if none.
REQ-004 highest_isr  in  8  one-hot highest in-service bit from the in-service register, or 0.
REQ-005 inta  in  1  one-cycle strobe per INTA pulse, already synchronized.
REQ-006 ocw2_write  in  1  one-cycle strobe; ocw2_data is valid in that cycle.
REQ-007 ocw2_data  in  8  bits[7:5] = R,SL,EOI; bits[2:0] = L2..L0.
REQ-008 auto_eoi  in  1  ICW4 AEOI mode bit, static during operation.
REQ-009 vector_base  in  5  ICW2 bits T7..T3.
REQ-010 int_out  out  1  registered interrupt request to the CPU.
REQ-011 in_service_flag  out  1  one-cycle pulse; in_service_vector is loaded into the ISR.
REQ-012 in_service_vector  out  8  one-hot bit to set in the ISR.
REQ-013 eoi  out  8  one-cycle mask of ISR bits to clear.
REQ-014 rotate  out  3  lowest-priority IR index; drives the in-service priority rotation.
REQ-015 vector_out  out  8  interrupt vector byte.
REQ-016 vector_enable  out  1  one-cycle pulse; vector_out is valid in that cycle.

Function
REQ-017 Priority level of IR n is (n - rotate - 1) mod 8; level 0 is the highest priority.
REQ-018 FSM states:
- IDLE -> PENDING when highest_request != 0 and its level < level of highest_isr (any level wins if highest_isr == 0).
- PENDING -> IDLE when highest_request becomes 0 or loses the comparison.
- IDLE/PENDING -> ACK1 on inta.
- ACK1 -> IDLE on inta.
REQ-019 int_out SHALL be 1 exactly while the state is PENDING (registered, asserted one cycle after the condition).
REQ-020 On the first inta, the controller SHALL latch highest_request as the acknowledged bit.
- If the latch is nonzero: assert in_service_flag for one cycle, with in_service_vector = latch, in the next cycle.
- If the latch is zero (spurious): no in_service_flag, and the acknowledged index is 7.
REQ-021 On the second inta, the next cycle SHALL drive vector_out = {vector_base, index} and vector_enable = 1 for one cycle.
REQ-022 In AEOI mode, on the second inta and a nonzero latch:
- Assert eoi = latch in the same cycle as vector_enable.
- If the rotate_in_aeoi flag is set, rotate takes the acknowledged index in that cycle.
REQ-023 OCW2 commands (R,SL,EOI), each taking effect in the cycle after ocw2_write:
- 001: eoi = highest_isr.
- 011: eoi = 1<<L.
- 101: eoi = highest_isr and rotate = index(highest_isr).
- 111: eoi = 1<<L and rotate = L.
- 110: rotate = L.
- 100: set rotate_in_aeoi.
- 000: clear rotate_in_aeoi.
- 010: no-op.
REQ-024 Non-specific EOI or rotate with highest_isr == 0 SHALL produce eoi = 0 and leave rotate unchanged.
REQ-025 eoi SHALL be 0 in every cycle without an EOI event; in_service_flag and vector_enable are 0 outside their pulse cycles.
REQ-026 OCW2 and an AEOI event in the same cycle: eoi = OR of both masks; the OCW2 rotate update wins.
REQ-027 inta in the same cycle as a state transition condition: the inta transition takes precedence.
REQ-028 Request changes after the first inta SHALL NOT alter the latched bit or the vector.

Reset
REQ-029 Reset values:
- state = IDLE, rotate = 3'b111, rotate_in_aeoi = 0, latch = 0.
- int_out, in_service_flag, in_service_vector, eoi, vector_out, vector_enable all 0.
REQ-030 Reset asserted mid-acknowledge SHALL abort the sequence, with no pending pulses after release.

Verification
V1 Setup: rotate=7, vector_base=5'h08, highest_request=8'h04, highest_isr=0.
- Required: int_out=1.
- First inta -> in_service_flag pulse with vector 8'h04.
- Second inta -> vector_out=8'h42, vector_enable pulse.
V2 highest_isr=8'h02, highest_request=8'h08, rotate=7 -> int_out stays 0. With rotate=1 (IR2 highest) -> int_out=1.
V3 Setup: auto_eoi=1, OCW2 8'h80 (sets rotate_in_aeoi), acknowledge IR5.
- Required: eoi=8'h20 with vector_enable, then rotate=5.
V4 highest_request drops to 0 before the first inta -> no in_service_flag; the second inta gives vector_out={vector_base,3'b111}.
V5 OCW2 8'hE3 with highest_isr=8'h08 -> eoi=8'h08 for one cycle and rotate=3. Then OCW2 8'h20 with highest_isr=0 -> eoi=0.
V6 Reset pulse between the first and second inta -> all outputs 0, rotate=7. A subsequent inta is treated as a new first inta.
